if_id_pipe_buf: RTL and testbench
=================================

// Module: if_id_pipe_buf
// PURPOSE
//  Parametrised IF/ID pipeline stage. Replaces the bare IF/ID latch with a valid/ready stage: a 2-slot skid buffer, flush, and a stall counter.
//  Sits between instruction fetch (upstream) and decode (downstream). Slices the held instruction into MIPS fields for the decoder.
//  Load-use stalls arrive as out_ready=0; branch/jump redirects arrive as flush.
// PARAMETERS
//  PC_W     32     width of PC carried with each instruction
//  INS_W    32     instruction width (field slicing defined for 32 only)
//  NOP_INS  32'h0  instruction presented while stage holds no valid entry
//  CNT_W    16     width of saturating stall counter
// PORTS
//  clk        in   1       stage clock; all state updates on negedge clk, as for the other pipeline registers
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       IF presents instruction
//  in_ready   out  1       stage can accept (registered: skid slot empty)
//  in_pc      in   PC_W    PC of fetched instruction
//  in_ins     in   INS_W   fetched instruction
//  flush      in   1       discard all held entries (taken branch/jump)
//  out_valid  out  1       main slot holds valid instruction
//  out_ready  in   1       ID accepts; 0 = stall (load-use)
//  out_pc     out  PC_W    PC of main slot
//  out_ins    out  INS_W   instruction of main slot (NOP_INS when invalid)
//  op/rs/rt/rd/shf/func  out 6/5/5/5/5/6   out_ins[31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0]
//  imm16      out  16      out_ins[15:0]
//  target     out  26      out_ins[25:0]
//  stall_cnt  out  CNT_W   cycles main slot was valid but not accepted
// BEHAVIOUR
//  State: main slot M {v,pc,ins}, skid slot S {v,pc,ins}. in_fire = in_valid&in_ready; out_fire = M.v&out_ready.
//  Reset (async, immediate): M.v=S.v=0, M.ins=S.ins=NOP_INS, pcs=0, stall_cnt=0, in_ready=1. Outputs follow M.
//  Per negedge, priority order:
//   1 flush: M.v=S.v=0, M.ins=NOP_INS; in_fire that edge discarded; in_ready=1 next. Flush beats stall and input.
//   2 out_fire or !M.v: M <= S if S.v, else in if in_fire, else M.v=0/M.ins=NOP_INS. If S.v: S <= in if in_fire else S.v=0.
//   3 M held (M.v & !out_ready): in_fire loads S (S.v=1 -> in_ready=0 next).
//  in_ready == !S.v (register output, no comb path from out_ready). Never drop/duplicate/reorder; FIFO order in->S->M.
//  Latency: empty stage, in_fire at edge N -> out_valid from edge N. Full throughput 1/cycle with out_ready=1.
//  Both slots full and stall: in_ready=0, upstream holds; contents unchanged.
//  stall_cnt: +1 each edge with M.v & !out_ready & !flush; saturates at all-ones; cleared only by rst.
//  Field outputs pure slices of out_ins (combinational from M), so invalid stage decodes as NOP.
//  Reset mid-stall/mid-skid: all entries lost, counter cleared; no partial state survives.
// STRUCTURE
//  Shared package mips_pkg: field bit positions (OP_HI..FUNC_LO), NOP_INS default, PC_W/INS_W defaults.
//  One sub-module natural: pipe_slot (valid+payload register with load/clear), instantiated for M and S.
//  Field slicing and stall counter stay in the top.
// TESTING
//  Stream 4 instrs PC 0x0,4,8,C, out_ready=1 -> out_valid 4 consecutive edges, same order, stall_cnt=0.
//  Load-use: M=0x8C010004 held, out_ready=0 2 edges, in 0x00221820 -> S filled, in_ready=0, stall_cnt=2; release -> 0x8C010004 then 0x00221820.
//  Flush with M and S full plus in_valid -> next edge out_valid=0, out_ins=0, in_ready=1, new input dropped.
//  Field slice: out_ins=0x012A4020 -> op=0, rs=9, rt=10, rd=8, shf=0, func=0x20, imm16=0x4020.
//  Saturation: CNT_W=4, stall 20 edges -> stall_cnt=15, stays 15.
//  Async rst asserted between edges mid-stall -> outputs reset immediately; no entry reappears after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: default widths, NOP encoding and instruction field positions.
package mips_pkg;

    localparam int unsigned PC_W_DEF  = 32;
    localparam int unsigned INS_W_DEF = 32;
    localparam int unsigned CNT_W_DEF = 16;

    localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;

    // Field bit positions within a 32-bit MIPS instruction
    localparam int unsigned OP_HI   = 31;
    localparam int unsigned OP_LO   = 26;
    localparam int unsigned RS_HI   = 25;
    localparam int unsigned RS_LO   = 21;
    localparam int unsigned RT_HI   = 20;
    localparam int unsigned RT_LO   = 16;
    localparam int unsigned RD_HI   = 15;
    localparam int unsigned RD_LO   = 11;
    localparam int unsigned SHF_HI  = 10;
    localparam int unsigned SHF_LO  = 6;
    localparam int unsigned FUNC_HI = 5;
    localparam int unsigned FUNC_LO = 0;
    localparam int unsigned IMM_HI  = 15;
    localparam int unsigned IMM_LO  = 0;
    localparam int unsigned TGT_HI  = 25;
    localparam int unsigned TGT_LO  = 0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus PC/instruction payload, updated on the falling clock edge.
// Clear beats load; a cleared slot shows NOP_INS and keeps its last PC.
module pipe_slot
    import mips_pkg::*;
#(
    parameter int unsigned         PC_W    = PC_W_DEF,
    parameter int unsigned         INS_W   = INS_W_DEF,
    parameter logic [INS_W-1:0]    NOP_INS = INS_W'(NOP_INS_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [INS_W-1:0] ins_i,
    output logic             valid_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [INS_W-1:0] ins_o
);

    logic             valid_q;
    logic [PC_W-1:0]  pc_q;
    logic [INS_W-1:0] ins_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ins_q   <= NOP_INS;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_INS;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            ins_q   <= ins_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign ins_o   = ins_q;

endmodule

// File: rtl/if_id_pipe_buf.sv
// IF/ID valid/ready stage: main slot M feeds decode, skid slot S absorbs one fetch during a stall.
// Field outputs are plain slices of the main-slot instruction (field slicing assumes INS_W == 32).
module if_id_pipe_buf
    import mips_pkg::*;
#(
    parameter int unsigned      PC_W    = PC_W_DEF,
    parameter int unsigned      INS_W   = INS_W_DEF,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF),
    parameter int unsigned      CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    output logic [5:0]       op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shf,
    output logic [5:0]       func,
    output logic [15:0]      imm16,
    output logic [25:0]      target,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             m_v, s_v;
    logic [PC_W-1:0]  m_pc, s_pc, m_pc_d;
    logic [INS_W-1:0] m_ins, s_ins, m_ins_d;
    logic             m_load, m_clr, m_from_s, s_load, s_clr;
    logic             s_v_d;
    logic             in_fire, out_fire, stall_inc;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = m_v & out_ready;
    assign stall_inc = m_v & ~out_ready & ~flush;

    // Slot control: flush, then advance/refill of M, then skid capture while M is held
    always_comb begin
        m_load   = 1'b0;
        m_clr    = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        s_clr    = 1'b0;
        s_v_d    = s_v;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
            s_v_d = 1'b0;
        end else if (out_fire || !m_v) begin
            if (s_v) begin
                m_load   = 1'b1;
                m_from_s = 1'b1;
                if (in_fire) begin
                    s_load = 1'b1;
                end else begin
                    s_clr = 1'b1;
                    s_v_d = 1'b0;
                end
            end else if (in_fire) begin
                m_load = 1'b1;
            end else begin
                m_clr = 1'b1;
            end
        end else if (in_fire) begin
            s_load = 1'b1;
            s_v_d  = 1'b1;
        end
    end

    assign m_pc_d  = m_from_s ? s_pc  : in_pc;
    assign m_ins_d = m_from_s ? s_ins : in_ins;

    assign cnt_d = (stall_inc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    pipe_slot #(.PC_W(PC_W), .INS_W(INS_W), .NOP_INS(NOP_INS)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (m_load),
        .clear_i (m_clr),
        .pc_i    (m_pc_d),
        .ins_i   (m_ins_d),
        .valid_o (m_v),
        .pc_o    (m_pc),
        .ins_o   (m_ins)
    );

    pipe_slot #(.PC_W(PC_W), .INS_W(INS_W), .NOP_INS(NOP_INS)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (s_load),
        .clear_i (s_clr),
        .pc_i    (in_pc),
        .ins_i   (in_ins),
        .valid_o (s_v),
        .pc_o    (s_pc),
        .ins_o   (s_ins)
    );

    // in_ready mirrors the next skid-empty state so it carries no path from out_ready
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            in_ready_q <= ~s_v_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_v;
    assign out_pc    = m_pc;
    assign out_ins   = m_ins;
    assign stall_cnt = cnt_q;

    assign op     = m_ins[OP_HI:OP_LO];
    assign rs     = m_ins[RS_HI:RS_LO];
    assign rt     = m_ins[RT_HI:RT_LO];
    assign rd     = m_ins[RD_HI:RD_LO];
    assign shf    = m_ins[SHF_HI:SHF_LO];
    assign func   = m_ins[FUNC_HI:FUNC_LO];
    assign imm16  = m_ins[IMM_HI:IMM_LO];
    assign target = m_ins[TGT_HI:TGT_LO];

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Bench for if_id_pipe_buf: directed scenarios plus random traffic against a two-entry FIFO model.
`timescale 1ns/1ps
module tb_if_id_pipe_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_ins;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_ins;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shf;
    logic [15:0] imm16;
    logic [25:0] target;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4;
    logic [31:0] out_pc4, out_ins4;
    logic [5:0]  op4, func4;
    logic [4:0]  rs4, rt4, rd4, shf4;
    logic [15:0] imm16_4;
    logic [25:0] target4;
    logic [3:0]  stall_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stage contents as an ordered list of at most two entries
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    int          cnt16;
    int          cnt4;

    if_id_pipe_buf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ins(in_ins), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shf(shf), .func(func),
        .imm16(imm16), .target(target), .stall_cnt(stall_cnt)
    );

    if_id_pipe_buf #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_ins(in_ins), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .out_pc(out_pc4), .out_ins(out_ins4),
        .op(op4), .rs(rs4), .rt(rt4), .rd(rd4), .shf(shf4), .func(func4),
        .imm16(imm16_4), .target(target4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        cnt16 = 0;
        cnt4  = 0;
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = (q_ins.size() < 2);
        if (flush) begin
            q_pc.delete();
            q_ins.delete();
        end else begin
            if (q_ins.size() > 0 && !out_ready) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            if (q_ins.size() > 0 && out_ready) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (in_valid && rdy) begin
                q_pc.push_back(in_pc);
                q_ins.push_back(in_ins);
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] ei;
        bit          ev;
        ev = (q_ins.size() > 0);
        ei = ev ? q_ins[0] : 32'h0;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready",  64'(in_ready),  64'(q_ins.size() < 2));
        chk("out_ins",   64'(out_ins),   64'(ei));
        if (ev) chk("out_pc", 64'(out_pc), 64'(q_pc[0]));
        chk("op",     64'(op),     64'(ei >> 26));
        chk("rs",     64'(rs),     64'((ei >> 21) & 32'h1F));
        chk("rt",     64'(rt),     64'((ei >> 16) & 32'h1F));
        chk("rd",     64'(rd),     64'((ei >> 11) & 32'h1F));
        chk("shf",    64'(shf),    64'((ei >> 6) & 32'h1F));
        chk("func",   64'(func),   64'(ei & 32'h3F));
        chk("imm16",  64'(imm16),  64'(ei & 32'hFFFF));
        chk("target", 64'(target), 64'(ei & 32'h03FF_FFFF));
        chk("stall_cnt",  64'(stall_cnt),  64'(cnt16));
        chk("stall_cnt4", 64'(stall_cnt4), 64'(cnt4));
        chk("out_ins4",   64'(out_ins4),   64'(ei));
        chk("in_ready4",  64'(in_ready4),  64'(q_ins.size() < 2));
    endtask

    // Drive one set of inputs, let the falling edge act on them, then sample after the rising edge
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit fl, input bit ordy);
        in_valid  = v;
        in_pc     = pc;
        in_ins    = ins;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_ins = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_ins",  64'(out_ins),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming at full throughput
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1);
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_pc",    64'(out_pc),    64'(i * 4));
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("stream_stall", 64'(stall_cnt), 64'(0));

        // Load-use stall with skid capture
        cycle(1'b1, 32'h100, 32'h8C01_0004, 1'b0, 1'b1);
        cycle(1'b1, 32'h104, 32'h0022_1820, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,   32'h0,         1'b0, 1'b0);
        chk("lu_in_ready", 64'(in_ready),  64'(0));
        chk("lu_stall",    64'(stall_cnt), 64'(2));
        chk("lu_held",     64'(out_ins),   64'(32'h8C01_0004));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("lu_second",   64'(out_ins),   64'(32'h0022_1820));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("lu_drained",  64'(out_valid), 64'(0));

        // Flush with both slots full and a new fetch presented
        cycle(1'b1, 32'h300, 32'h2408_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h2409_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'h308, 32'h240A_0003, 1'b1, 1'b0);
        chk("fl_valid",    64'(out_valid), 64'(0));
        chk("fl_ins",      64'(out_ins),   64'(0));
        chk("fl_in_ready", 64'(in_ready),  64'(1));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("fl_dropped",  64'(out_valid), 64'(0));

        // Field slicing
        cycle(1'b1, 32'h400, 32'h012A_4020, 1'b0, 1'b0);
        chk("f_op",   64'(op),    64'(0));
        chk("f_rs",   64'(rs),    64'(9));
        chk("f_rt",   64'(rt),    64'(10));
        chk("f_rd",   64'(rd),    64'(8));
        chk("f_shf",  64'(shf),   64'(0));
        chk("f_func", 64'(func),  64'(6'h20));
        chk("f_imm",  64'(imm16), 64'(16'h4020));

        // Long stall saturates the narrow counter
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_15", 64'(stall_cnt4), 64'(15));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_hold", 64'(stall_cnt4), 64'(15));

        // Asynchronous reset between edges while stalled with the skid full
        cycle(1'b1, 32'h500, 32'h1234_5678, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_stall", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("ar_gone", 64'(out_valid), 64'(0));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
